prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the instruction-memory word-address width (16K words = 64 KB).
REQ-002 Parameter TIMEOUT, default 1_000_000, SHALL set the maximum idle clock cycles allowed between accepted bytes during a load.
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port load_start  input  1  SHALL be a one-cycle request to begin a program download.
REQ-006 Port byte_in  input  8  SHALL carry a received byte, qualified by byte_valid.
REQ-007 Port byte_valid  input  1  SHALL be a one-cycle strobe; every strobe SHALL be consumed, with no backpressure.
REQ-008 Port imem_we  output  1  SHALL be the instruction-memory write strobe, one cycle per word.
REQ-009 Port imem_addr  output  ADDR_W  SHALL be the word address for the write.
REQ-010 Port imem_wdata  output  32  SHALL be the instruction word to write.
REQ-011 Port cpu_hold  output  1  SHALL hold the fetch unit/CPU in reset while a load is active.
REQ-012 Port busy, done, error  output  1 each  SHALL report load in progress, successful completion, and failed load.

Function
REQ-013 Frame format SHALL be: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes (little-endian per word), then one CSUM byte.
REQ-014 The FSM SHALL use states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
REQ-015 IDLE->LEN_LO on load_start; LEN_LO->LEN_HI on a byte; LEN_HI->DATA on a byte if N>0, else ->CSUM.
REQ-016 DATA SHALL assemble bytes into a 32-bit shift register with byte k of each word placed at bits [8k+7:8k].
REQ-017 On the 4th byte of a word, imem_we SHALL pulse for exactly one cycle on the following cycle, with imem_addr = word index (starting at 0) and imem_wdata = the assembled word.
REQ-018 After word N-1 is written, DATA->CSUM.
REQ-019 The checksum SHALL be the XOR of LEN_LO, LEN_HI and all data bytes; in CSUM a matching byte->DONE, a mismatch->ERR.
REQ-020 If N > 2**ADDR_W, LEN_HI SHALL go ->ERR and no write SHALL occur.
REQ-021 In LEN_LO, LEN_HI, DATA and CSUM, TIMEOUT cycles without byte_valid SHALL force ->ERR; the timer SHALL reset on every accepted byte.
REQ-022 load_start while busy SHALL be ignored; load_start in DONE or ERR SHALL restart at LEN_LO and clear done/error.
REQ-023 byte_valid in IDLE, DONE or ERR SHALL be discarded.
REQ-024 If load_start and byte_valid coincide in IDLE, the byte SHALL be discarded.
REQ-025 busy and cpu_hold SHALL be high exactly in states LEN_LO through CSUM; done is high only in DONE, error only in ERR.
REQ-026 The word counter SHALL be ADDR_W+1 bits wide so that N = 2**ADDR_W is accepted without wrap; imem_addr SHALL never exceed 2**ADDR_W-1.

Reset
REQ-027 Reset SHALL asynchronously force IDLE, with imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, busy=0, done=0, error=0; the checksum, counters and timer SHALL all be cleared.
REQ-028 Reset mid-load SHALL abandon the frame; no further imem_we SHALL occur until a new load_start.

Structure
REQ-029 State encodings and the frame-field constants SHALL live in the shared package cpu_defs_pkg.
REQ-030 The timeout counter SHALL be a sub-module named loader_timer (inputs: restart, enable; output: expired).

Verification
REQ-031 N=2 frame 02 00, then bytes 24 08 00 05 and 8C 01 00 00, then correct CSUM -> writes addr0=0x05000824 and addr1=0x0000018C, then done=1, cpu_hold=0.
REQ-032 N=0 frame 00 00 with CSUM 00 -> no imem_we, DONE; CSUM 01 instead -> ERR, error=1.
REQ-033 N=0x4001 with ADDR_W=14 -> ERR immediately after LEN_HI, and no write.
REQ-034 TIMEOUT=100; stop sending after 6 data bytes -> error rises 100 cycles after the last byte, and only one write occurs (addr 0).
REQ-035 Assert reset after the 2nd data byte, then do a full N=1 load -> the single write goes to addr 0 with the correct data.
REQ-036 Pulse load_start during DATA -> it is ignored and the frame completes normally; load_start in DONE -> done clears and LEN_LO is entered.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the program loader: FSM state encodings,
// frame-field sizes and a state-class helper.
package cpu_defs_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  // States in which a frame is being received and the CPU must stay held.
  function automatic logic is_loading(input logic [2:0] s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write bus and load status of the loader.
interface prog_loader_if #(
  parameter int ADDR_W = 14
);

  // byte_valid is a single-cycle strobe with no ready: the loader consumes
  // every strobe (or discards it when not loading), imem_we is a one-cycle
  // write strobe qualifying imem_addr/imem_wdata, and memory never stalls.
  logic              load_start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output load_start, byte_in, byte_valid,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
  );

  modport slave (
    input  load_start, byte_in, byte_valid,
    output imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
  );

endinterface

// File: rtl/loader_timer.sv
// Inter-byte idle timer: expires after TIMEOUT enabled cycles without a restart.
module loader_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

  // Fires on the TIMEOUT-th idle edge after the last restart.
  assign expired = enable && !restart && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed, checksummed byte frame and
// writes it word by word into instruction memory while holding the CPU.
module prog_loader
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic          clock,
  input  logic          reset,
  prog_loader_if.slave  bus,
  output logic [2:0]    state_dbg
);

  logic [2:0]       state;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] word_total;
  logic [ADDR_W:0]  word_cnt;
  logic [1:0]       byte_cnt;
  logic [31:0]      shreg;
  logic [7:0]       csum;
  logic             loading;
  logic             byte_take;
  logic             expired;
  logic [LEN_W-1:0] len_n;
  logic [31:0]      shreg_next;

  assign loading    = is_loading(state);
  assign byte_take  = loading && bus.byte_valid;
  assign len_n      = {bus.byte_in, len_lo};
  assign shreg_next = {bus.byte_in, shreg[31:8]};

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .restart (byte_take),
    .enable  (loading),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      len_lo        <= '0;
      word_total    <= '0;
      word_cnt      <= '0;
      byte_cnt      <= '0;
      shreg         <= '0;
      csum          <= '0;
      bus.imem_we   <= 1'b0;
      bus.imem_addr <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (expired) begin
        state <= S_ERR;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (bus.load_start) begin
              state <= S_LEN_LO;
              csum  <= '0;
            end
          end
          S_LEN_LO: begin
            if (bus.byte_valid) begin
              len_lo <= bus.byte_in;
              csum   <= csum ^ bus.byte_in;
              state  <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (bus.byte_valid) begin
              csum       <= csum ^ bus.byte_in;
              word_total <= len_n;
              word_cnt   <= '0;
              byte_cnt   <= '0;
              // The word count may equal the memory size but never exceed it.
              if ({16'd0, len_n} > (32'd1 << ADDR_W)) begin
                state <= S_ERR;
              end else if (len_n == '0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (bus.byte_valid) begin
              csum     <= csum ^ bus.byte_in;
              shreg    <= shreg_next;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                bus.imem_we   <= 1'b1;
                bus.imem_addr <= word_cnt[ADDR_W-1:0];
                word_cnt      <= word_cnt + (ADDR_W+1)'(1);
                if ((32'(word_cnt) + 32'd1) == {16'd0, word_total}) begin
                  state <= S_CSUM;
                end
              end
            end
          end
          S_CSUM: begin
            if (bus.byte_valid) begin
              state <= (bus.byte_in == csum) ? S_DONE : S_ERR;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // After the fourth byte the shift register holds the finished word.
  assign bus.imem_wdata = shreg;
  assign bus.busy       = loading;
  assign bus.cpu_hold   = loading;
  assign bus.done       = (state == S_DONE);
  assign bus.error      = (state == S_ERR);
  assign state_dbg      = state;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: fixed frame vectors, multi-cycle corner sequences and
// random frames checked against a frame-level reference model.
module tb_prog_loader;
  import cpu_defs_pkg::*;

  localparam int AW   = 14;
  localparam int AW_S = 3;
  localparam int TMO  = 100;
  localparam int OUT_BUSY = 0;
  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       ls [2];
  logic       bv [2];
  logic [7:0] bi;
  logic [2:0] st [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [45:0] exp_q   [$];
  logic [45:0] exp_q_s [$];
  logic [7:0]  fr_q    [$];

  prog_loader_if #(.ADDR_W(AW))   bus_m ();
  prog_loader_if #(.ADDR_W(AW_S)) bus_s ();

  assign bus_m.load_start = ls[0];
  assign bus_m.byte_valid = bv[0];
  assign bus_m.byte_in    = bi;
  assign bus_s.load_start = ls[1];
  assign bus_s.byte_valid = bv[1];
  assign bus_s.byte_in    = bi;

  prog_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .bus(bus_m.slave), .state_dbg(st[0])
  );

  prog_loader #(.ADDR_W(AW_S), .TIMEOUT(TMO)) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s.slave), .state_dbg(st[1])
  );

  function automatic logic [3:0] status(input int sel);
    if (sel == 0) return {bus_m.busy, bus_m.cpu_hold, bus_m.done, bus_m.error};
    return {bus_s.busy, bus_s.cpu_hold, bus_s.done, bus_s.error};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: write monitors ----------------
  always @(negedge clock) begin
    if (bus_m.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write_m: addr 0x%0h data 0x%0h, required no write",
                 bus_m.imem_addr, bus_m.imem_wdata);
      end else begin
        check("imem_write_m", {18'd0, bus_m.imem_addr, bus_m.imem_wdata}, {18'd0, exp_q.pop_front()});
      end
    end
    if (bus_s.imem_we === 1'b1) begin
      if (exp_q_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write_s: addr 0x%0h data 0x%0h, required no write",
                 bus_s.imem_addr, bus_s.imem_wdata);
      end else begin
        check("imem_write_s", {29'd0, bus_s.imem_addr, bus_s.imem_wdata}, {18'd0, exp_q_s.pop_front()});
      end
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send_byte(input int sel, input logic [7:0] b);
    bi      = b;
    bv[sel] = 1'b1;
    @(negedge clock);
    bv[sel] = 1'b0;
  endtask

  task automatic pulse_start(input int sel);
    ls[sel] = 1'b1;
    @(negedge clock);
    ls[sel] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  // Interprets fr_q as a frame: queues the writes it implies and returns the outcome
  // reached once every byte is in (OUT_BUSY when the frame is cut short).
  function automatic int model(input int sel, input int aw);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    if (fr_q.size() < 2) return OUT_BUSY;
    n = int'({fr_q[1], fr_q[0]});
    x = fr_q[0] ^ fr_q[1];
    if (n > (1 << aw)) return OUT_ERR;
    for (int i = 0; i < n; i++) begin
      if (fr_q.size() < 2 + 4 * i + 4) return OUT_BUSY;
      w = {fr_q[2+4*i+3], fr_q[2+4*i+2], fr_q[2+4*i+1], fr_q[2+4*i]};
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      if (sel == 0) exp_q.push_back({14'(i), w});
      else          exp_q_s.push_back({14'(i), w});
    end
    if (fr_q.size() < 3 + 4 * n) return OUT_BUSY;
    return (fr_q[2+4*n] == x) ? OUT_DONE : OUT_ERR;
  endfunction

  task automatic build_frame(input int n, input bit corrupt);
    logic [7:0] b;
    logic [7:0] x;
    fr_q = {};
    fr_q.push_back(8'(n));
    fr_q.push_back(8'(n >> 8));
    x = 8'(n) ^ 8'(n >> 8);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(255, 0));
      fr_q.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'($urandom_range(255, 1));
    fr_q.push_back(x);
  endtask

  task automatic run_model_frame(input int sel, input int aw, input string tag, input int gap_max);
    int         outc;
    int         cnt;
    logic [3:0] s;
    outc = model(sel, aw);
    pulse_start(sel);
    foreach (fr_q[i]) begin
      send_byte(sel, fr_q[i]);
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
    if (outc == OUT_BUSY) begin
      cnt = 0;
      s   = status(sel);
      while (s[0] !== 1'b1 && cnt < TMO + 20) begin
        @(negedge clock);
        cnt++;
        s = status(sel);
      end
      outc = OUT_ERR;
    end
    idle(1);
    s = status(sel);
    check({tag, "_done"},  {63'd0, s[1]}, {63'd0, outc == OUT_DONE});
    check({tag, "_error"}, {63'd0, s[0]}, {63'd0, outc == OUT_ERR});
    check({tag, "_busy"},  {62'd0, s[3:2]}, 64'd0);
    check({tag, "_writes_left"}, 64'(sel == 0 ? exp_q.size() : exp_q_s.size()), 64'd0);
    exp_q   = {};
    exp_q_s = {};
  endtask

  // ---------------- fixed vectors ----------------
  typedef struct {
    int          nbytes;
    logic [7:0]  bytes [12];
    int          nw;
    logic [31:0] words [2];
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic set_vec(input int idx, input int nb, input logic [95:0] pb, input int nw,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic d, input logic e);
    vecs[idx].nbytes = nb;
    for (int k = 0; k < 12; k++) vecs[idx].bytes[k] = pb[95-8*k -: 8];
    vecs[idx].nw       = nw;
    vecs[idx].words[0] = w0;
    vecs[idx].words[1] = w1;
    vecs[idx].exp_done = d;
    vecs[idx].exp_err  = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] s;
    int         cnt;
    int         sel;
    int         kill;
    ls[0] = 1'b0; ls[1] = 1'b0;
    bv[0] = 1'b0; bv[1] = 1'b0;
    bi    = 8'h00;

    set_vec(0, 11, 96'h02_00_24_08_00_05_8C_01_00_00_A6_00, 2, 32'h05000824, 32'h0000018C, 1'b1, 1'b0);
    set_vec(1, 3,  96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b1, 1'b0);
    set_vec(2, 3,  96'h00_00_01_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0, 1'b1);
    set_vec(3, 2,  96'h01_40_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0, 1'b1);
    set_vec(4, 7,  96'h01_00_EF_BE_AD_DE_23_00_00_00_00_00, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0);
    set_vec(5, 7,  96'h01_00_EF_BE_AD_DE_24_00_00_00_00_00, 1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    set_vec(6, 7,  96'h01_00_78_56_34_12_09_00_00_00_00_00, 1, 32'h12345678, 32'h0, 1'b1, 1'b0);

    // Reset values
    idle(2);
    check("rst_status",  {60'd0, status(0)}, 64'd0);
    check("rst_we",      {63'd0, bus_m.imem_we}, 64'd0);
    check("rst_addr",    {50'd0, bus_m.imem_addr}, 64'd0);
    check("rst_wdata",   {32'd0, bus_m.imem_wdata}, 64'd0);
    check("rst_state",   {61'd0, st[0]}, {61'd0, S_IDLE});
    reset = 1'b0;
    idle(1);

    // Table-driven frames
    foreach (vecs[i]) begin
      pulse_start(0);
      for (int k = 0; k < vecs[i].nw; k++) exp_q.push_back({14'(k), vecs[i].words[k]});
      for (int k = 0; k < vecs[i].nbytes; k++) send_byte(0, vecs[i].bytes[k]);
      s = status(0);
      check($sformatf("vec%0d_done", i),  {63'd0, s[1]}, {63'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_error", i), {63'd0, s[0]}, {63'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_hold", i),  {62'd0, s[3:2]}, 64'd0);
      check($sformatf("vec%0d_writes_left", i), 64'(exp_q.size()), 64'd0);
      exp_q = {};
      idle(2);
    end

    // Timeout after 6 data bytes: one write, error exactly TMO cycles later
    pulse_start(0);
    exp_q.push_back({14'd0, 32'h44332211});
    send_byte(0, 8'h02); send_byte(0, 8'h00);
    send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33);
    send_byte(0, 8'h44); send_byte(0, 8'h55); send_byte(0, 8'h66);
    cnt = 0;
    s   = status(0);
    while (s[0] !== 1'b1 && cnt < TMO + 50) begin
      @(negedge clock);
      cnt++;
      s = status(0);
    end
    check("timeout_cycles", 64'(cnt), 64'(TMO));
    check("timeout_hold", {62'd0, s[3:2]}, 64'd0);
    check("timeout_writes_left", 64'(exp_q.size()), 64'd0);
    exp_q = {};

    // Reset mid-frame, stray bytes in IDLE, then a clean N=1 load
    pulse_start(0);
    send_byte(0, 8'h01); send_byte(0, 8'h00);
    send_byte(0, 8'hAA); send_byte(0, 8'hBB);
    #2 reset = 1'b1;
    #1;
    check("midrst_state",  {61'd0, st[0]}, {61'd0, S_IDLE});
    check("midrst_status", {60'd0, status(0)}, 64'd0);
    check("midrst_addr",   {50'd0, bus_m.imem_addr}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    send_byte(0, 8'hCC); send_byte(0, 8'hDD);
    idle(3);
    check("idle_discard_state", {61'd0, st[0]}, {61'd0, S_IDLE});
    build_frame(1, 1'b0);
    run_model_frame(0, AW, "after_reset", 0);

    // load_start during DATA is ignored; write strobe follows the 4th byte
    build_frame(2, 1'b0);
    void'(model(0, AW));
    pulse_start(0);
    for (int k = 0; k < fr_q.size(); k++) begin
      send_byte(0, fr_q[k]);
      if (k == 4) pulse_start(0);
      if (k == 5) begin
        check("we_after_4th", {63'd0, bus_m.imem_we}, 64'd1);
        check("we_addr0", {50'd0, bus_m.imem_addr}, 64'd0);
      end
      if (k == 6) check("we_one_cycle", {63'd0, bus_m.imem_we}, 64'd0);
    end
    s = status(0);
    check("ignore_start_done", {60'd0, s}, 64'b0010);
    check("ignore_start_writes_left", 64'(exp_q.size()), 64'd0);
    pulse_start(0);
    s = status(0);
    check("restart_from_done_status", {60'd0, s}, 64'b1100);
    check("restart_from_done_state", {61'd0, st[0]}, {61'd0, S_LEN_LO});
    send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h00);
    check("restart_frame_done", {63'd0, bus_m.done}, 64'd1);

    // load_start with a coincident byte in IDLE: byte dropped
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ls[0] = 1'b1; bi = 8'h01; bv[0] = 1'b1;
    @(negedge clock);
    ls[0] = 1'b0; bv[0] = 1'b0;
    check("coincide_state", {61'd0, st[0]}, {61'd0, S_LEN_LO});
    send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h00);
    check("coincide_done", {63'd0, bus_m.done}, 64'd1);

    // Size boundary on the narrow instance: 2**AW_S words accepted, one more rejected
    build_frame(1 << AW_S, 1'b0);
    run_model_frame(1, AW_S, "full_mem", 0);
    build_frame((1 << AW_S) + 1, 1'b0);
    run_model_frame(1, AW_S, "over_mem", 0);

    // Random frames: lengths, gaps, corrupted checksums and truncations
    for (int t = 0; t < 24; t++) begin
      sel = (t % 3 == 2) ? 1 : 0;
      build_frame(sel == 1 ? $urandom_range(10, 0) : $urandom_range(6, 0),
                  $urandom_range(3, 0) == 0);
      if ($urandom_range(6, 0) == 0) begin
        kill = $urandom_range(fr_q.size(), 1);
        repeat (kill) void'(fr_q.pop_back());
      end
      run_model_frame(sel, sel == 1 ? AW_S : AW, $sformatf("rnd%0d", t), 3);
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
